// File: rtl/down_counter.sv
// Loadable down counter with optional auto-reload, terminal-count pulse and a
// saturating count of terminal events since the last accepted load.
module down_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_value,
  output logic             load_ready,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] cnt,
  output logic             busy,
  output logic             done,
  output logic [7:0]       expire_cnt
);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StRun     = 2'd1,
    StExpired = 2'd2
  } state_e;

  localparam logic [WIDTH-1:0] CntOne  = WIDTH'(1);
  localparam logic [WIDTH-1:0] CntZero = '0;
  localparam logic [7:0]       ExpMax  = 8'hFF;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             load_ready_q, load_ready_d;
  logic [7:0]       expire_cnt_q, expire_cnt_d;

  logic load_accept;
  logic terminal;
  logic [7:0] expire_inc;

  // load_ready_q already encodes "not in RUN", so it gates loads directly.
  assign load_accept = load_valid & load_ready_q;
  assign terminal    = (state_q == StRun) & enable & (cnt_q == CntOne);
  assign expire_inc  = (expire_cnt_q == ExpMax) ? ExpMax : expire_cnt_q + 8'd1;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    reload_d     = reload_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    load_ready_d = load_ready_q;
    expire_cnt_d = expire_cnt_q;

    if (rst) begin
      state_d      = StIdle;
      cnt_d        = CntZero;
      reload_d     = CntZero;
      busy_d       = 1'b0;
      load_ready_d = 1'b1;
      expire_cnt_d = 8'd0;
    end else begin
      unique case (state_q)
        StIdle, StExpired: begin
          if (load_accept) begin
            cnt_d    = load_value;
            reload_d = load_value;
            if (load_value == CntZero) begin
              // A zero load is its own terminal event.
              state_d      = StExpired;
              busy_d       = 1'b0;
              done_d       = 1'b1;
              load_ready_d = 1'b1;
              expire_cnt_d = 8'd1;
            end else begin
              state_d      = StRun;
              busy_d       = 1'b1;
              load_ready_d = 1'b0;
              expire_cnt_d = 8'd0;
            end
          end
        end
        StRun: begin
          if (terminal) begin
            done_d       = 1'b1;
            expire_cnt_d = expire_inc;
            if (auto_reload) begin
              cnt_d = reload_q;
            end else begin
              cnt_d        = CntZero;
              state_d      = StExpired;
              busy_d       = 1'b0;
              load_ready_d = 1'b1;
            end
          end else if (enable && (cnt_q > CntOne)) begin
            cnt_d = cnt_q - CntOne;
          end
        end
        default: begin
          state_d      = StIdle;
          cnt_d        = CntZero;
          busy_d       = 1'b0;
          load_ready_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    state_q      <= state_d;
    cnt_q        <= cnt_d;
    reload_q     <= reload_d;
    busy_q       <= busy_d;
    done_q       <= done_d;
    load_ready_q <= load_ready_d;
    expire_cnt_q <= expire_cnt_d;
  end

  assign cnt        = cnt_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign load_ready = load_ready_q;
  assign expire_cnt = expire_cnt_q;

endmodule

// File: tb/tb_down_counter.sv
// Bench for down_counter: directed scenarios with literal expectations, then
// random stimulus, with every cycle compared against a behavioural model.
module tb_down_counter;
  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         enable;
  logic         load_valid;
  logic [W-1:0] load_value;
  logic         load_ready;
  logic         auto_reload;
  logic [W-1:0] cnt;
  logic         busy;
  logic         done;
  logic [7:0]   expire_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  down_counter #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .load_valid (load_valid),
    .load_value (load_value),
    .load_ready (load_ready),
    .auto_reload(auto_reload),
    .cnt        (cnt),
    .busy       (busy),
    .done       (done),
    .expire_cnt (expire_cnt)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a counter that is either running or not, plus counts.
  bit      m_valid = 1'b0;
  bit      m_running;
  bit      m_done;
  longint  m_cnt;
  longint  m_reload;
  longint  m_exp;

  always @(posedge clk) begin
    if (rst) begin
      m_valid   = 1'b1;
      m_running = 1'b0;
      m_done    = 1'b0;
      m_cnt     = 0;
      m_reload  = 0;
      m_exp     = 0;
    end else if (m_valid) begin
      m_done = 1'b0;
      if (!m_running) begin
        if (load_valid) begin
          m_cnt    = load_value;
          m_reload = load_value;
          m_exp    = 0;
          if (load_value == 0) begin
            m_done = 1'b1;
            m_exp  = 1;
          end else begin
            m_running = 1'b1;
          end
        end
      end else if (enable) begin
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) begin
          m_done = 1'b1;
          if (m_exp < 255) m_exp = m_exp + 1;
          if (auto_reload) m_cnt = m_reload;
          else m_running = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("m_cnt", cnt, m_cnt);
      chk("m_busy", busy, m_running);
      chk("m_done", done, m_done);
      chk("m_ready", load_ready, !m_running);
      chk("m_expire", expire_cnt, m_exp);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    load_valid = 1'b0;
    cyc(2);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0; enable = 1'b0; load_valid = 1'b0; load_value = '0; auto_reload = 1'b0;
    @(negedge clk);
    do_reset();
    chk("rst_cnt", cnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", load_ready, 1);
    chk("rst_expire", expire_cnt, 0);

    // Load 10, single shot.
    enable = 1'b1; auto_reload = 1'b0; load_valid = 1'b1; load_value = 16'd10;
    cyc(1);
    load_valid = 1'b0;
    chk("l10_cnt", cnt, 10);
    chk("l10_busy", busy, 1);
    for (int i = 9; i >= 0; i--) begin
      cyc(1);
      chk("l10_seq", cnt, i);
      chk("l10_done", done, (i == 0));
    end
    chk("l10_busy_end", busy, 0);
    chk("l10_expire", expire_cnt, 1);
    chk("l10_ready", load_ready, 1);

    // Load 3 with auto-reload, 12 enabled cycles.
    auto_reload = 1'b1; load_valid = 1'b1; load_value = 16'd3;
    cyc(1);
    load_valid = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      cyc(1);
      chk("ar3_cnt", cnt, 3 - (i % 3));
      chk("ar3_done", done, (i % 3 == 0));
    end
    chk("ar3_expire", expire_cnt, 4);
    chk("ar3_busy", busy, 1);

    // Load 5, pause at 3.
    do_reset();
    auto_reload = 1'b0; load_valid = 1'b1; load_value = 16'd5;
    cyc(1);
    load_valid = 1'b0;
    cyc(2);
    chk("pause_at", cnt, 3);
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      chk("pause_hold", cnt, 3);
      chk("pause_done", done, 0);
    end
    enable = 1'b1;
    for (int i = 2; i >= 0; i--) begin
      cyc(1);
      chk("resume_cnt", cnt, i);
      chk("resume_done", done, (i == 0));
    end

    // Load 8 with load_valid held through RUN.
    load_valid = 1'b1; load_value = 16'd8;
    cyc(1);
    load_value = 16'd99;
    chk("hold_cnt", cnt, 8);
    cyc(8);
    chk("hold_exp_cnt", cnt, 0);
    chk("hold_exp_cnt1", expire_cnt, 1);
    cyc(1);
    load_valid = 1'b0;
    chk("hold_reload", cnt, 99);
    chk("hold_expire0", expire_cnt, 0);

    // Reset on the terminal edge of a load of 4.
    do_reset();
    load_valid = 1'b1; load_value = 16'd4;
    cyc(1);
    load_valid = 1'b0;
    cyc(3);
    chk("rt_cnt1", cnt, 1);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk("rt_cnt", cnt, 0);
    chk("rt_done", done, 0);
    chk("rt_ready", load_ready, 1);
    chk("rt_busy", busy, 0);
    cyc(1);
    chk("rt_done2", done, 0);

    // Load 0, then load 1 with auto-reload.
    load_valid = 1'b1; load_value = 16'd0;
    cyc(1);
    load_valid = 1'b0;
    chk("z_cnt", cnt, 0);
    chk("z_done", done, 1);
    chk("z_expire", expire_cnt, 1);
    chk("z_ready", load_ready, 1);
    cyc(1);
    chk("z_done_off", done, 0);
    auto_reload = 1'b1; load_valid = 1'b1; load_value = 16'd1;
    cyc(1);
    load_valid = 1'b0;
    chk("one_cnt", cnt, 1);
    for (int i = 0; i < 300; i++) begin
      cyc(1);
      chk("one_done", done, 1);
      chk("one_cnt_hold", cnt, 1);
    end
    chk("one_sat", expire_cnt, 255);

    // Random phase.
    for (int i = 0; i < 4000; i++) begin
      rst         = ($urandom_range(0, 99) == 0);
      enable      = ($urandom_range(0, 3) != 0);
      load_valid  = ($urandom_range(0, 2) == 0);
      auto_reload = $urandom_range(0, 1);
      if ($urandom_range(0, 7) == 0) load_value = W'($urandom);
      else load_value = W'($urandom_range(0, 12));
      cyc(1);
    end
    rst = 1'b0;
    cyc(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
